// File: rtl/v850_pkg.sv
// Shared types and helpers for the operand-read / issue stage.
//   reg_idx_t : 5-bit general-register index
//   word_t    : 32-bit register / operand word
//   R0        : hardwired-zero register index
//   NREG/XLEN : register count and width
package v850_pkg;

    localparam int NREG   = 32;
    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;

    typedef logic [RIDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   word_t;

    localparam reg_idx_t R0 = '0;

    // True when an enabled port targets the given register index.
    function automatic logic idx_hit(input logic en, input reg_idx_t port_idx,
                                     input reg_idx_t idx);
        return en && (port_idx == idx);
    endfunction

    // Source read with same-cycle writeback bypass. Port 2 is checked first
    // because writeback lets port 2 win when both ports target one register.
    function automatic word_t fwd_operand(input reg_idx_t src,
                                          input word_t    gr_val,
                                          input logic     we,
                                          input reg_idx_t dst,
                                          input word_t    data,
                                          input logic     we2,
                                          input reg_idx_t dst2,
                                          input word_t    data2);
        word_t res;
        if (src == R0) begin
            res = '0;
        end else if (we2 && (dst2 == src)) begin
            res = data2;
        end else if (we && (dst == src)) begin
            res = data;
        end else begin
            res = gr_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register in-flight scoreboard.
// A bit is set when an instruction leaves the output slot for execute with
// that destination, and cleared when writeback retires the register.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   set_en/set_idx        : set request, primary destination
//   set2_en/set2_idx      : set request, second destination
//   clr_en/clr_idx        : clear request, writeback port 1
//   clr2_en/clr2_idx      : clear request, writeback port 2
//   q1_idx/q1_pend        : combinational query port 1
//   q2_idx/q2_pend        : combinational query port 2
//   pend_vec              : full pending vector (destination checks)
module operand_scoreboard
    import v850_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  reg_idx_t        set_idx,
    input  logic            set2_en,
    input  reg_idx_t        set2_idx,
    input  logic            clr_en,
    input  reg_idx_t        clr_idx,
    input  logic            clr2_en,
    input  reg_idx_t        clr2_idx,
    input  reg_idx_t        q1_idx,
    output logic            q1_pend,
    input  reg_idx_t        q2_idx,
    output logic            q2_pend,
    output logic [NREG-1:0] pend_vec
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // Clears are applied before sets so a same-cycle set on the same
    // register survives.
    always_comb begin
        sb_d = sb_q;
        if (clr_en)  sb_d[clr_idx]  = 1'b0;
        if (clr2_en) sb_d[clr2_idx] = 1'b0;
        if (set_en)  sb_d[set_idx]  = 1'b1;
        if (set2_en) sb_d[set2_idx] = 1'b1;
        sb_d[R0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign q1_pend  = sb_q[q1_idx];
    assign q2_pend  = sb_q[q2_idx];
    assign pend_vec = sb_q;

endmodule

// File: rtl/operand_read.sv
// Operand-read / issue stage.
// Reads two source operands for the decoded instruction from the GR array,
// bypassing same-cycle writeback data, stalls on RAW/WAW hazards against the
// scoreboard and the output slot, and presents the result to execute through
// a registered valid/ready slot.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   GR                         : architectural register array from writeback
//   dec_*                      : instruction from decode (valid/ready)
//   wb_*                       : writeback ports (same-cycle strobes)
//   flush                      : branch redirect, kills the output slot
//   ex_*                       : registered output slot to execute
module operand_read
    import v850_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  word_t    GR [NREG],
    input  logic     dec_valid,
    output logic     dec_ready,
    input  reg_idx_t dec_src1,
    input  reg_idx_t dec_src2,
    input  logic     dec_use1,
    input  logic     dec_use2,
    input  reg_idx_t dec_dst,
    input  reg_idx_t dec_dst2,
    input  logic     dec_we,
    input  logic     dec_we2,
    input  logic     wb_we,
    input  logic     wb_we2,
    input  reg_idx_t wb_dst,
    input  reg_idx_t wb_dst2,
    input  word_t    wb_data,
    input  word_t    wb_data2,
    input  logic     flush,
    output logic     ex_valid,
    input  logic     ex_ready,
    output word_t    ex_op1,
    output word_t    ex_op2,
    output reg_idx_t ex_dst,
    output reg_idx_t ex_dst2,
    output logic     ex_we,
    output logic     ex_we2
);

    logic     ex_valid_q, ex_valid_d;
    word_t    ex_op1_q,   ex_op1_d;
    word_t    ex_op2_q,   ex_op2_d;
    reg_idx_t ex_dst_q,   ex_dst_d;
    reg_idx_t ex_dst2_q,  ex_dst2_d;
    logic     ex_we_q,    ex_we_d;
    logic     ex_we2_q,   ex_we2_d;

    logic            sb_src1, sb_src2;
    logic [NREG-1:0] sb_vec;

    logic  slot_free, handshake, accept, hazard;
    logic  slot_src1, slot_src2, slot_dst1, slot_dst2;
    logic  wb_clr1, wb_clr2;
    logic  haz_src1, haz_src2, haz_dst1, haz_dst2;
    logic  sb_set_en, sb_set2_en;
    word_t rd_op1, rd_op2;

    operand_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set_en),
        .set_idx  (ex_dst_q),
        .set2_en  (sb_set2_en),
        .set2_idx (ex_dst2_q),
        .clr_en   (wb_we),
        .clr_idx  (wb_dst),
        .clr2_en  (wb_we2),
        .clr2_idx (wb_dst2),
        .q1_idx   (dec_src1),
        .q1_pend  (sb_src1),
        .q2_idx   (dec_src2),
        .q2_pend  (sb_src2),
        .pend_vec (sb_vec)
    );

    always_comb begin
        slot_free = !ex_valid_q || ex_ready;
        handshake = ex_valid_q && ex_ready;

        // The slot's destinations are pending until they reach the
        // scoreboard; their data cannot be on the writeback ports yet.
        slot_src1 = ex_valid_q && (idx_hit(ex_we_q, ex_dst_q, dec_src1) ||
                                   idx_hit(ex_we2_q, ex_dst2_q, dec_src1));
        slot_src2 = ex_valid_q && (idx_hit(ex_we_q, ex_dst_q, dec_src2) ||
                                   idx_hit(ex_we2_q, ex_dst2_q, dec_src2));
        slot_dst1 = ex_valid_q && (idx_hit(ex_we_q, ex_dst_q, dec_dst) ||
                                   idx_hit(ex_we2_q, ex_dst2_q, dec_dst));
        slot_dst2 = ex_valid_q && (idx_hit(ex_we_q, ex_dst_q, dec_dst2) ||
                                   idx_hit(ex_we2_q, ex_dst2_q, dec_dst2));

        wb_clr1 = idx_hit(wb_we, wb_dst, dec_src1) || idx_hit(wb_we2, wb_dst2, dec_src1);
        wb_clr2 = idx_hit(wb_we, wb_dst, dec_src2) || idx_hit(wb_we2, wb_dst2, dec_src2);

        // A scoreboarded source is released by a same-cycle writeback since
        // the bypass mux delivers that data; destinations wait for the clear.
        haz_src1 = dec_use1 && (dec_src1 != R0) && (slot_src1 || (sb_src1 && !wb_clr1));
        haz_src2 = dec_use2 && (dec_src2 != R0) && (slot_src2 || (sb_src2 && !wb_clr2));
        haz_dst1 = dec_we  && (dec_dst  != R0) && (slot_dst1 || sb_vec[dec_dst]);
        haz_dst2 = dec_we2 && (dec_dst2 != R0) && (slot_dst2 || sb_vec[dec_dst2]);

        hazard = haz_src1 || haz_src2 || haz_dst1 || haz_dst2;
        accept = dec_valid && slot_free && !hazard && !flush;

        // A flushed slot never reaches execute, so it must not mark its
        // destinations in flight.
        sb_set_en  = handshake && !flush && ex_we_q;
        sb_set2_en = handshake && !flush && ex_we2_q;
    end

    always_comb begin
        rd_op1 = fwd_operand(dec_src1, GR[dec_src1], wb_we, wb_dst, wb_data,
                             wb_we2, wb_dst2, wb_data2);
        rd_op2 = fwd_operand(dec_src2, GR[dec_src2], wb_we, wb_dst, wb_data,
                             wb_we2, wb_dst2, wb_data2);
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_dst_d   = ex_dst_q;
        ex_dst2_d  = ex_dst2_q;
        ex_we_d    = ex_we_q;
        ex_we2_d   = ex_we2_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            ex_op1_d   = rd_op1;
            ex_op2_d   = rd_op2;
            ex_dst_d   = dec_dst;
            ex_dst2_d  = dec_dst2;
            ex_we_d    = dec_we;
            ex_we2_d   = dec_we2;
        end else if (handshake) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_dst_q   <= '0;
            ex_dst2_q  <= '0;
            ex_we_q    <= 1'b0;
            ex_we2_q   <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_dst_q   <= ex_dst_d;
            ex_dst2_q  <= ex_dst2_d;
            ex_we_q    <= ex_we_d;
            ex_we2_q   <= ex_we2_d;
        end
    end

    assign dec_ready = slot_free && !hazard && !flush;
    assign ex_valid  = ex_valid_q;
    assign ex_op1    = ex_op1_q;
    assign ex_op2    = ex_op2_q;
    assign ex_dst    = ex_dst_q;
    assign ex_dst2   = ex_dst2_q;
    assign ex_we     = ex_we_q;
    assign ex_we2    = ex_we2_q;

endmodule

// File: tb/tb_operand_read.sv
module tb_operand_read;
    import v850_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    word_t    gr [NREG];
    logic     dec_valid, dec_ready;
    reg_idx_t dec_src1, dec_src2, dec_dst, dec_dst2;
    logic     dec_use1, dec_use2, dec_we, dec_we2;
    logic     wb_we, wb_we2;
    reg_idx_t wb_dst, wb_dst2;
    word_t    wb_data, wb_data2;
    logic     flush;
    logic     ex_valid, ex_ready;
    word_t    ex_op1, ex_op2;
    reg_idx_t ex_dst, ex_dst2;
    logic     ex_we, ex_we2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    operand_read dut (
        .clk(clk), .rst_n(rst_n), .GR(gr),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_src1(dec_src1), .dec_src2(dec_src2),
        .dec_use1(dec_use1), .dec_use2(dec_use2),
        .dec_dst(dec_dst), .dec_dst2(dec_dst2),
        .dec_we(dec_we), .dec_we2(dec_we2),
        .wb_we(wb_we), .wb_we2(wb_we2),
        .wb_dst(wb_dst), .wb_dst2(wb_dst2),
        .wb_data(wb_data), .wb_data2(wb_data2),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_dst(ex_dst), .ex_dst2(ex_dst2),
        .ex_we(ex_we), .ex_we2(ex_we2)
    );

    always @(posedge clk) begin
        if (rst_n && dec_valid && dec_we && dec_we2)
            assert (dec_dst != dec_dst2) else $error("FAIL illegal_dst_pair: dst=%0d dst2=%0d", dec_dst, dec_dst2);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        dec_valid = 0; dec_src1 = 0; dec_src2 = 0; dec_use1 = 0; dec_use2 = 0;
        dec_dst = 0; dec_dst2 = 0; dec_we = 0; dec_we2 = 0;
        wb_we = 0; wb_we2 = 0; wb_dst = 0; wb_dst2 = 0; wb_data = 0; wb_data2 = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREG; i++) gr[i] = 32'h0;
        idle();
        rst_n = 0;
        #3;
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        n_tests++; if (ex_op1 !== 32'h0 || ex_op2 !== 32'h0) begin n_fail++; $display("FAIL reset_ops: got %h/%h want 0/0", ex_op1, ex_op2); end
        n_tests++; if (ex_dst !== 5'd0 || ex_dst2 !== 5'd0 || ex_we !== 1'b0 || ex_we2 !== 1'b0) begin n_fail++; $display("FAIL reset_dst_we: got %0d/%0d/%b/%b want 0", ex_dst, ex_dst2, ex_we, ex_we2); end
        n_tests++; if (dut.u_sb.sb_q !== 32'h0) begin n_fail++; $display("FAIL reset_sb: got %h want 0", dut.u_sb.sb_q); end
        n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL reset_dec_ready: got %b want 1", dec_ready); end
        #10;
        rst_n = 1;
        step();
    endtask

    task automatic test_basic();
        idle();
        gr[3] = 32'h11; gr[4] = 32'h22;
        dec_valid = 1; dec_src1 = 3; dec_src2 = 4; dec_use1 = 1; dec_use2 = 1;
        dec_dst = 5; dec_we = 1; dec_dst2 = 6; dec_we2 = 1;
        #2;
        n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", dec_ready); end
        step();
        n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", ex_valid); end
        n_tests++; if (ex_op1 !== 32'h11 || ex_op2 !== 32'h22) begin n_fail++; $display("FAIL basic_ops: got %h/%h want 11/22", ex_op1, ex_op2); end
        n_tests++; if (ex_dst !== 5'd5 || ex_dst2 !== 5'd6 || ex_we !== 1'b1 || ex_we2 !== 1'b1) begin n_fail++; $display("FAIL basic_dst: got %0d/%0d/%b/%b want 5/6/1/1", ex_dst, ex_dst2, ex_we, ex_we2); end
        idle();
        step();
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", ex_valid); end
        n_tests++; if (dut.u_sb.sb_q[6:5] !== 2'b11) begin n_fail++; $display("FAIL basic_sb_set: got %b want 11", dut.u_sb.sb_q[6:5]); end
        wb_we = 1; wb_dst = 5; wb_we2 = 1; wb_dst2 = 6;
        step();
        idle();
        n_tests++; if (dut.u_sb.sb_q[6:5] !== 2'b00) begin n_fail++; $display("FAIL basic_sb_clr: got %b want 00", dut.u_sb.sb_q[6:5]); end
    endtask

    task automatic test_r0();
        idle();
        gr[0] = 32'hDEAD;
        dec_valid = 1; dec_src1 = 0; dec_use1 = 1; dec_src2 = 3; dec_use2 = 1;
        step();
        n_tests++; if (ex_op1 !== 32'h0 || ex_op2 !== 32'h11) begin n_fail++; $display("FAIL r0_ops: got %h/%h want 0/11", ex_op1, ex_op2); end
        idle();
        gr[0] = 32'h0;
        step();
    endtask

    task automatic test_forward();
        idle();
        gr[7] = 32'h7777; gr[8] = 32'h8888;
        dec_valid = 1; dec_src1 = 7; dec_src2 = 7; dec_use1 = 1; dec_use2 = 1;
        wb_we = 1; wb_dst = 7; wb_data = 32'hAAAA;
        wb_we2 = 1; wb_dst2 = 7; wb_data2 = 32'hBBBB;
        step();
        n_tests++; if (ex_op1 !== 32'hBBBB || ex_op2 !== 32'hBBBB) begin n_fail++; $display("FAIL fwd_port2_prio: got %h/%h want BBBB/BBBB", ex_op1, ex_op2); end
        dec_src2 = 8; wb_dst2 = 8; wb_data2 = 32'hCCCC;
        step();
        n_tests++; if (ex_op1 !== 32'hAAAA || ex_op2 !== 32'hCCCC) begin n_fail++; $display("FAIL fwd_split: got %h/%h want AAAA/CCCC", ex_op1, ex_op2); end
        wb_we = 0; wb_we2 = 0;
        step();
        n_tests++; if (ex_op1 !== 32'h7777 || ex_op2 !== 32'h8888) begin n_fail++; $display("FAIL fwd_none: got %h/%h want 7777/8888", ex_op1, ex_op2); end
        idle();
        step();
    endtask

    task automatic test_raw();
        idle();
        gr[9] = 32'h9999;
        dec_valid = 1; dec_dst = 9; dec_we = 1;
        step();
        n_tests++; if (ex_valid !== 1'b1 || ex_dst !== 5'd9) begin n_fail++; $display("FAIL raw_issue: got %b/%0d want 1/9", ex_valid, ex_dst); end
        dec_src1 = 9; dec_use1 = 1; dec_dst = 10; dec_we = 1;
        wb_we = 1; wb_dst = 9; wb_data = 32'h5555;
        #2;
        n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_slot_no_fwd: got %b want 0", dec_ready); end
        step();
        n_tests++; if (dut.u_sb.sb_q[9] !== 1'b1) begin n_fail++; $display("FAIL raw_set_wins: got %b want 1", dut.u_sb.sb_q[9]); end
        wb_we = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall[%0d]: got %b want 0", i, dec_ready); end
            step();
        end
        wb_we = 1; wb_dst = 9; wb_data = 32'h1234;
        #2;
        n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", dec_ready); end
        step();
        n_tests++; if (ex_op1 !== 32'h1234 || ex_dst !== 5'd10) begin n_fail++; $display("FAIL raw_fwd_op: got %h/%0d want 1234/10", ex_op1, ex_dst); end
        n_tests++; if (dut.u_sb.sb_q[9] !== 1'b0) begin n_fail++; $display("FAIL raw_sb_clr: got %b want 0", dut.u_sb.sb_q[9]); end
        idle();
        step();
        n_tests++; if (dut.u_sb.sb_q[10] !== 1'b1) begin n_fail++; $display("FAIL waw_sb_set: got %b want 1", dut.u_sb.sb_q[10]); end
        dec_valid = 1; dec_dst = 10; dec_we = 1;
        #2;
        n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b want 0", dec_ready); end
        idle();
        wb_we = 1; wb_dst = 10;
        step();
        idle();
        n_tests++; if (dut.u_sb.sb_q[10] !== 1'b0) begin n_fail++; $display("FAIL waw_sb_clr: got %b want 0", dut.u_sb.sb_q[10]); end
    endtask

    task automatic test_backpressure();
        idle();
        ex_ready = 0;
        dec_valid = 1; dec_src1 = 3; dec_src2 = 4; dec_use1 = 1; dec_use2 = 1; dec_dst = 11; dec_we = 1;
        step();
        dec_src1 = 4; dec_src2 = 3; dec_dst = 13;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, dec_ready); end
            n_tests++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h11 || ex_op2 !== 32'h22 || ex_dst !== 5'd11)
                begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h/%h/%0d want 1/11/22/11", i, ex_valid, ex_op1, ex_op2, ex_dst); end
            step();
        end
        ex_ready = 1;
        #2;
        n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", dec_ready); end
        step();
        n_tests++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h22 || ex_op2 !== 32'h11 || ex_dst !== 5'd13)
            begin n_fail++; $display("FAIL bp_next: got %b/%h/%h/%0d want 1/22/11/13", ex_valid, ex_op1, ex_op2, ex_dst); end
        n_tests++; if (dut.u_sb.sb_q[11] !== 1'b1) begin n_fail++; $display("FAIL bp_sb11: got %b want 1", dut.u_sb.sb_q[11]); end
        idle();
        step();
        n_tests++; if (ex_valid !== 1'b0 || dut.u_sb.sb_q[13] !== 1'b1) begin n_fail++; $display("FAIL bp_drain: got %b/%b want 0/1", ex_valid, dut.u_sb.sb_q[13]); end
        wb_we = 1; wb_dst = 11; wb_we2 = 1; wb_dst2 = 13;
        step();
        idle();
        n_tests++; if (dut.u_sb.sb_q !== 32'h0) begin n_fail++; $display("FAIL bp_sb_clr: got %h want 0", dut.u_sb.sb_q); end
    endtask

    task automatic test_flush();
        idle();
        gr[12] = 32'hC0C0;
        ex_ready = 0;
        dec_valid = 1; dec_dst = 12; dec_we = 1;
        step();
        n_tests++; if (ex_valid !== 1'b1 || ex_dst !== 5'd12) begin n_fail++; $display("FAIL flush_issue: got %b/%0d want 1/12", ex_valid, ex_dst); end
        dec_dst = 14; flush = 1;
        #2;
        n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", dec_ready); end
        step();
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %b want 0", ex_valid); end
        n_tests++; if (dut.u_sb.sb_q[12] !== 1'b0 || dut.u_sb.sb_q[14] !== 1'b0) begin n_fail++; $display("FAIL flush_sb: got %b/%b want 0/0", dut.u_sb.sb_q[12], dut.u_sb.sb_q[14]); end
        idle();
        dec_valid = 1; dec_src1 = 12; dec_use1 = 1;
        #2;
        n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL flush_no_stall: got %b want 1", dec_ready); end
        step();
        n_tests++; if (ex_valid !== 1'b1 || ex_op1 !== 32'hC0C0) begin n_fail++; $display("FAIL flush_after_op: got %b/%h want 1/C0C0", ex_valid, ex_op1); end
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        dec_valid = 1; dec_dst = 15; dec_we = 1;
        step();
        dec_dst = 16;
        step();
        n_tests++; if (dut.u_sb.sb_q[15] !== 1'b1 || ex_valid !== 1'b1 || ex_dst !== 5'd16)
            begin n_fail++; $display("FAIL rstmid_pre: got %b/%b/%0d want 1/1/16", dut.u_sb.sb_q[15], ex_valid, ex_dst); end
        idle();
        #2;
        rst_n = 0;
        #1;
        n_tests++; if (ex_valid !== 1'b0 || ex_dst !== 5'd0 || dut.u_sb.sb_q !== 32'h0)
            begin n_fail++; $display("FAIL rstmid_async: got %b/%0d/%h want 0/0/0", ex_valid, ex_dst, dut.u_sb.sb_q); end
        #3;
        rst_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_r0();
        test_forward();
        test_raw();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
